// File: rtl/tracker_pkg.sv
// ============================================================================
// Module      : tracker_pkg
// Description : Shared axis FSM state encoding and motor drive codes for the
//               N-axis tracker controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tracker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    EVAL   = 3'd2,
    MOVE   = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } axis_state_t;

  localparam logic [1:0] DRV_OFF  = 2'b00;
  localparam logic [1:0] DRV_SLOW = 2'b01;
  localparam logic [1:0] DRV_FAST = 2'b10;

endpackage

`default_nettype wire

// File: rtl/tracker_axis.sv
// ============================================================================
// Module      : tracker_axis
// Description : Single-axis tracker FSM with deadband, paced MOVE intervals and
//               step timeout. Optional soft position limits under SOFT_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tracker_axis
  import tracker_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEADBAND  = 4,
  parameter int FAST_THR  = 64,
  parameter int STEP_DIV  = 1000,
`ifdef SOFT_LIMIT_EN
  parameter logic [DATA_W-1:0] POS_MIN = '0,
  parameter logic [DATA_W-1:0] POS_MAX = '1,
`endif
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] sens_a,
  input  logic [DATA_W-1:0] sens_b,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] pos_actual,
  output logic [1:0]        out_pos,
  output logic [1:0]        out_neg,
  output logic              aligned,
  output logic              fault
);

  localparam int CNT_W  = $clog2(STEP_DIV);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [DATA_W:0] c_deadband  = (DATA_W+1)'(DEADBAND);
  localparam logic [DATA_W:0] c_fast_thr  = (DATA_W+1)'(FAST_THR);
  localparam logic [CNT_W-1:0] c_div_last = CNT_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0] c_max_steps = STEP_W'(MAX_STEPS);

  axis_state_t         r_state, w_next;
  logic [DATA_W-1:0]   r_a, r_b, r_target, r_pos;
  logic                r_mode;
  logic [CNT_W-1:0]    r_int_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [1:0]          r_out_pos, r_out_neg;
  logic                r_aligned, r_fault;

  logic signed [DATA_W:0] w_err;
  logic [DATA_W:0]     w_mag;
  logic                w_in_band, w_fast, w_dir_pos, w_limit, w_int_done, w_timeout;
  logic [1:0]          w_code, w_pos_nxt, w_neg_nxt;
  logic                w_aligned_nxt, w_fault_nxt;

  // Zero-extended operands keep the difference exact over the full unsigned range.
  assign w_err = r_mode ? ($signed({1'b0, r_a}) - $signed({1'b0, r_b}))
                        : ($signed({1'b0, r_target}) - $signed({1'b0, r_pos}));
  assign w_mag      = w_err[DATA_W] ? $unsigned(-w_err) : $unsigned(w_err);
  assign w_in_band  = (w_mag <= c_deadband);
  assign w_fast     = (w_mag > c_fast_thr);
  assign w_dir_pos  = ~w_err[DATA_W];
  assign w_int_done = (r_int_cnt == c_div_last);
  assign w_timeout  = (r_step_cnt == c_max_steps);
  assign w_code     = w_fast ? DRV_FAST : DRV_SLOW;

`ifdef SOFT_LIMIT_EN
  assign w_limit = (w_dir_pos && (r_pos >= POS_MAX)) || (!w_dir_pos && (r_pos <= POS_MIN));
`else
  assign w_limit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_out_pos <= DRV_OFF;
      r_out_neg <= DRV_OFF;
      r_aligned <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_out_pos <= w_pos_nxt;
      r_out_neg <= w_neg_nxt;
      r_aligned <= w_aligned_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!start) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = SAMPLE;
        SAMPLE:  w_next = EVAL;
        EVAL: begin
          if (w_in_band || w_limit) w_next = DONE;
          else if (w_timeout)       w_next = FAULT;
          else                      w_next = MOVE;
        end
        MOVE:    if (w_int_done) w_next = SAMPLE;
        DONE:    if (w_int_done) w_next = SAMPLE;
        FAULT:   w_next = FAULT;
        default: w_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state.
  always_comb begin
    w_pos_nxt     = DRV_OFF;
    w_neg_nxt     = DRV_OFF;
    w_aligned_nxt = (w_next == DONE);
    w_fault_nxt   = (w_next == FAULT);
    if (w_next == MOVE) begin
      if (r_state == EVAL) begin
        w_pos_nxt = w_dir_pos ? w_code : DRV_OFF;
        w_neg_nxt = w_dir_pos ? DRV_OFF : w_code;
      end else begin
        w_pos_nxt = r_out_pos;
        w_neg_nxt = r_out_neg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_target   <= '0;
      r_pos      <= '0;
      r_mode     <= 1'b0;
      r_int_cnt  <= '0;
      r_step_cnt <= '0;
    end else begin
      if (r_state == SAMPLE) begin
        r_a      <= sens_a;
        r_b      <= sens_b;
        r_target <= target;
        r_pos    <= pos_actual;
        r_mode   <= mode;
      end
      if ((w_next == r_state) && ((r_state == MOVE) || (r_state == DONE)))
        r_int_cnt <= r_int_cnt + 1'b1;
      else
        r_int_cnt <= '0;
      if ((w_next == IDLE) || (w_next == DONE))
        r_step_cnt <= '0;
      else if ((r_state == EVAL) && (w_next == MOVE))
        r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  assign out_pos = r_out_pos;
  assign out_neg = r_out_neg;
  assign aligned = r_aligned;
  assign fault   = r_fault;

endmodule

`default_nettype wire

// File: rtl/tracker_axis_ctrl.sv
// ============================================================================
// Module      : tracker_axis_ctrl
// Description : N-axis closed-loop tracker; one tracker_axis per axis on sliced
//               flat buses. SOFT_LIMIT_EN adds POS_MIN/POS_MAX soft limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tracker_axis_ctrl
  import tracker_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int N_AXES    = 2,
  parameter int DEADBAND  = 4,
  parameter int FAST_THR  = 64,
  parameter int STEP_DIV  = 1000,
`ifdef SOFT_LIMIT_EN
  parameter logic [DATA_W-1:0] POS_MIN = '0,
  parameter logic [DATA_W-1:0] POS_MAX = '1,
`endif
  parameter int MAX_STEPS = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_AXES-1:0]        mode,
  input  logic [N_AXES*DATA_W-1:0] sens_a,
  input  logic [N_AXES*DATA_W-1:0] sens_b,
  input  logic [N_AXES*DATA_W-1:0] target,
  input  logic [N_AXES*DATA_W-1:0] pos_actual,
  output logic [2*N_AXES-1:0]      out_pos,
  output logic [2*N_AXES-1:0]      out_neg,
  output logic [N_AXES-1:0]        aligned,
  output logic [N_AXES-1:0]        fault
);

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    tracker_axis #(
      .DATA_W    (DATA_W),
      .DEADBAND  (DEADBAND),
      .FAST_THR  (FAST_THR),
      .STEP_DIV  (STEP_DIV),
`ifdef SOFT_LIMIT_EN
      .POS_MIN   (POS_MIN),
      .POS_MAX   (POS_MAX),
`endif
      .MAX_STEPS (MAX_STEPS)
    ) u_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode[i]),
      .sens_a     (sens_a[i*DATA_W +: DATA_W]),
      .sens_b     (sens_b[i*DATA_W +: DATA_W]),
      .target     (target[i*DATA_W +: DATA_W]),
      .pos_actual (pos_actual[i*DATA_W +: DATA_W]),
      .out_pos    (out_pos[2*i +: 2]),
      .out_neg    (out_neg[2*i +: 2]),
      .aligned    (aligned[i]),
      .fault      (fault[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_tracker_axis_ctrl.sv
// ============================================================================
// Module      : tb_tracker_axis_ctrl
// Description : Scoreboard bench for tracker_axis_ctrl (2 axes, STEP_DIV=8,
//               MAX_STEPS=3); soft-limit scenario built with SOFT_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tracker_axis_ctrl;

  localparam int S = 8;
  localparam logic [1:0] SL = 2'b01;
  localparam logic [1:0] FA = 2'b10;
  localparam logic [1:0] OF = 2'b00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] sens_a = '0, sens_b = '0, target = '0, pos_actual = '0;
  logic [3:0]  out_pos, out_neg;
  logic [1:0]  aligned, fault;

  typedef struct {
    logic [11:0] exp;
    logic [11:0] mask;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  tracker_axis_ctrl #(
    .DATA_W    (16),
    .N_AXES    (2),
    .DEADBAND  (4),
    .FAST_THR  (64),
    .STEP_DIV  (S),
`ifdef SOFT_LIMIT_EN
    .POS_MIN   (16'd0),
    .POS_MAX   (16'd100),
`endif
    .MAX_STEPS (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .sens_a     (sens_a),
    .sens_b     (sens_b),
    .target     (target),
    .pos_actual (pos_actual),
    .out_pos    (out_pos),
    .out_neg    (out_neg),
    .aligned    (aligned),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {out_pos, out_neg, aligned, fault};
  endfunction

  // Expected vector: axis0/axis1 drive codes, aligned and fault bits.
  function automatic logic [11:0] ex(input logic [1:0] p0, n0, p1, n1, al, fl);
    return {p1, p0, n1, n0, al, fl};
  endfunction

  function automatic exp_t mk(input logic [11:0] v, input logic [11:0] m, input string n);
    exp_t r;
    r.exp = v; r.mask = m; r.name = n;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_axis(input int ax, input logic m, input logic [15:0] a, b, t, p);
    mode[ax] = m;
    sens_a[ax*16 +: 16] = a;
    sens_b[ax*16 +: 16] = b;
    target[ax*16 +: 16] = t;
    pos_actual[ax*16 +: 16] = p;
  endtask

  task automatic test_reset_abort();
    rst_n = 1'b0; start = 1'b0;
    sb.push_back(mk(12'h000, 12'hfff, "reset_state"));
    tick(1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    rst_n = 1'b1;
    set_axis(0, 1'b0, 16'd0, 16'd0, 16'd100, 16'd50);
    set_axis(1, 1'b0, 16'd0, 16'd0, 16'd50, 16'd100);
    start = 1'b1;
    sb.push_back(mk(ex(SL, OF, OF, SL, 2'b00, 2'b00), 12'hfff, "move_before_reset"));
    sb.push_back(mk(12'h000, 12'hfff, "async_reset_mid_move"));
    sb.push_back(mk(ex(SL, OF, OF, SL, 2'b00, 2'b00), 12'hfff, "move_after_reset"));
    sb.push_back(mk(12'h000, 12'hfff, "abort_to_idle"));
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    #2 rst_n = 1'b0;
    #1;
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    tick(1);
    rst_n = 1'b1;
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b0;
    tick(1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
  endtask

  task automatic test_auto();
    set_axis(0, 1'b1, 16'd30, 16'd20, 16'd0, 16'd50);
    set_axis(1, 1'b0, 16'd0, 16'd0, 16'd50, 16'd50);
    start = 1'b1;
    sb.push_back(mk(12'h000, 12'hfff, "auto_latency_2"));
    sb.push_back(mk(ex(SL, OF, OF, OF, 2'b10, 2'b00), 12'hfff, "auto_first_drive"));
    sb.push_back(mk(ex(SL, OF, OF, OF, 2'b10, 2'b00), 12'hfff, "auto_hold_ignore_inputs"));
    sb.push_back(mk(12'h000, 12'hfff, "auto_resample"));
    sb.push_back(mk(ex(OF, OF, OF, OF, 2'b11, 2'b00), 12'hfff, "auto_aligned"));
    sb.push_back(mk(12'h000, 12'hfff, "auto_abort"));
    tick(2);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    tick(1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    sens_a[15:0] = 16'd10;
    tick(S - 1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    sens_a[15:0] = 16'd25;
    sens_b[15:0] = 16'd25;
    tick(1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    tick(2);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b0;
    tick(1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
  endtask

  task automatic test_fast_neg();
    set_axis(0, 1'b0, 16'd0, 16'd0, 16'd3, 16'd200);
    set_axis(1, 1'b1, 16'd200, 16'd100, 16'd0, 16'd50);
    start = 1'b1;
    sb.push_back(mk(ex(OF, FA, FA, OF, 2'b00, 2'b00), 12'hfff, "fast_codes"));
    sb.push_back(mk(ex(OF, SL, SL, OF, 2'b00, 2'b00), 12'hfff, "slow_codes_thr_edge"));
    sb.push_back(mk(ex(OF, OF, OF, OF, 2'b11, 2'b00), 12'hfff, "deadband_edge_aligned"));
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    pos_actual[15:0] = 16'd8;
    sens_a[31:16] = 16'd164;
    tick(S + 2);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    pos_actual[15:0] = 16'd7;
    sens_b[31:16] = 16'd164;
    tick(S + 2);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b0;
    tick(1);
  endtask

  task automatic test_timeout();
    set_axis(0, 1'b0, 16'd0, 16'd0, 16'd150, 16'd50);
    set_axis(1, 1'b0, 16'd0, 16'd0, 16'd20, 16'd20);
    start = 1'b1;
    sb.push_back(mk(ex(FA, OF, OF, OF, 2'b10, 2'b00), 12'hfff, "to_move1"));
    sb.push_back(mk(ex(FA, OF, OF, OF, 2'b10, 2'b00), 12'hfff, "to_move3_end"));
    sb.push_back(mk(ex(OF, OF, OF, OF, 2'b10, 2'b01), 12'hfff, "to_fault"));
    sb.push_back(mk(ex(OF, OF, OF, OF, 2'b00, 2'b01), 12'h337, "to_fault_held"));
    sb.push_back(mk(12'h000, 12'hfff, "to_cleared_by_start"));
    sb.push_back(mk(ex(FA, OF, OF, OF, 2'b10, 2'b00), 12'hfff, "to_restart"));
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    tick(2 * (S + 2) + S - 1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    tick(3 * S);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b0;
    tick(1);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b1;
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b0;
    tick(1);
  endtask

  task automatic test_independence();
    set_axis(0, 1'b0, 16'd0, 16'd0, 16'd40, 16'd40);
    set_axis(1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd50);
    start = 1'b1;
    for (int k = 0; k < S; k++)
      sb.push_back(mk(ex(OF, OF, OF, SL, 2'b01, 2'b00), 12'hfff, $sformatf("indep_cycle%0d", k)));
    tick(3);
    for (int k = 0; k < S; k++) begin
      e = sb.pop_front(); n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
      n_checks++;
      if (((out_pos[1:0] != 2'b00) && (out_neg[1:0] != 2'b00)) ||
          ((out_pos[3:2] != 2'b00) && (out_neg[3:2] != 2'b00))) begin
        n_fail++;
        $display("FAIL indep_exclusive_cycle%0d: got pos=%b neg=%b required no axis with both nonzero", k, out_pos, out_neg);
      end
      tick(1);
    end
    start = 1'b0;
    tick(1);
  endtask

`ifdef SOFT_LIMIT_EN
  task automatic test_soft_limit();
    set_axis(0, 1'b0, 16'd0, 16'd0, 16'd150, 16'd100);
    set_axis(1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    start = 1'b1;
    sb.push_back(mk(ex(OF, OF, OF, OF, 2'b11, 2'b00), 12'hfff, "soft_limit_max"));
    tick(3);
    e = sb.pop_front(); n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin n_fail++; $display("FAIL %s: got=%h exp=%h", e.name, obs(), e.exp); end
    start = 1'b0;
    tick(1);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset_abort();
    test_auto();
    test_fast_neg();
    test_timeout();
    test_independence();
`ifdef SOFT_LIMIT_EN
    test_soft_limit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
